// File: rtl/pending_req_table.sv
`default_nettype none
// ============================================================================
// Module   : pending_req_table
// Purpose  : Tag-allocating pending-request table with occupancy/flag view.
// Revision : 1.0 - initial release
// ============================================================================
module pending_req_table #(
    parameter int SIZE  = 8,
    parameter int DATAW = 32,
    parameter int TAGW  = $clog2(SIZE),
    parameter int SIZEW = $clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acquire_valid,
    input  logic [DATAW-1:0] acquire_data,
    output logic             acquire_ready,
    output logic [TAGW-1:0]  acquire_tag,
    input  logic             release_valid,
    input  logic [TAGW-1:0]  release_tag,
    output logic [DATAW-1:0] release_data,
    output logic             empty,
    output logic             full,
    output logic [SIZEW-1:0] size
);

    localparam logic signed [SIZEW:0] c_full_count = (SIZEW + 1)'(SIZE);

    logic [SIZE-1:0]         r_valid;
    logic [DATAW-1:0]        r_data [SIZE];
    logic [SIZEW-1:0]        r_count;
    logic                    r_empty;
    logic                    r_full;

    logic [TAGW-1:0]         w_alloc_tag;
    logic                    w_fire;
    logic                    w_release;
    logic signed [SIZEW:0]   w_count_next;

    // Lowest free index wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        w_alloc_tag = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_tag = TAGW'(i);
            end
        end
    end

    assign w_fire    = acquire_valid && !r_full;
    // An illegal release of a free entry must not disturb the count.
    assign w_release = release_valid && r_valid[release_tag];

    assign w_count_next = $signed({1'b0, r_count})
                        + $signed({{SIZEW{1'b0}}, w_fire})
                        - $signed({{SIZEW{1'b0}}, w_release});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_release) begin
                r_valid[release_tag] <= 1'b0;
            end
            if (w_fire) begin
                r_valid[w_alloc_tag] <= 1'b1;
            end
            r_count <= w_count_next[SIZEW-1:0];
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == c_full_count);
        end
    end

    // Metadata storage carries no reset; entries are only read while valid.
    always_ff @(posedge clk) begin
        if (!reset && w_fire) begin
            r_data[w_alloc_tag] <= acquire_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && release_valid) begin
            assert (r_valid[release_tag])
                else $error("pending_req_table: release of unallocated tag %0d", release_tag);
        end
    end

    assign acquire_ready = !r_full;
    assign acquire_tag   = w_alloc_tag;
    assign release_data  = r_data[release_tag];
    assign empty         = r_empty;
    assign full          = r_full;
    assign size          = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pending_req_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_pending_req_table
// Purpose  : Directed and randomized self-checking bench for pending_req_table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pending_req_table;

    localparam int SIZE  = 8;
    localparam int DATAW = 32;
    localparam int TAGW  = 3;
    localparam int SIZEW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             acquire_valid;
    logic [DATAW-1:0] acquire_data;
    logic             acquire_ready;
    logic [TAGW-1:0]  acquire_tag;
    logic             release_valid;
    logic [TAGW-1:0]  release_tag;
    logic [DATAW-1:0] release_data;
    logic             empty;
    logic             full;
    logic [SIZEW-1:0] size;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a set of held tags and the metadata stored under each.
    bit               m_valid [SIZE];
    logic [DATAW-1:0] m_data  [SIZE];

    pending_req_table #(.SIZE(SIZE), .DATAW(DATAW), .TAGW(TAGW), .SIZEW(SIZEW)) dut (
        .clk           (clk),
        .reset         (reset),
        .acquire_valid (acquire_valid),
        .acquire_data  (acquire_data),
        .acquire_ready (acquire_ready),
        .acquire_tag   (acquire_tag),
        .release_valid (release_valid),
        .release_tag   (release_tag),
        .release_data  (release_data),
        .empty         (empty),
        .full          (full),
        .size          (size)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int c = 0;
        foreach (m_valid[i]) c += int'(m_valid[i]);
        return c;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < SIZE; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    task automatic apply(input bit av, input logic [DATAW-1:0] ad,
                         input bit rv, input logic [TAGW-1:0] rt);
        acquire_valid = av;
        acquire_data  = ad;
        release_valid = rv;
        release_tag   = rt;
        #1;
    endtask

    task automatic tick();
        bit fire;
        int t;
        fire = acquire_valid && (m_count() < SIZE);
        t    = m_free();
        @(posedge clk);
        #1;
        if (reset) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else begin
            if (release_valid) m_valid[release_tag] = 1'b0;
            if (fire) begin
                m_valid[t] = 1'b1;
                m_data[t]  = acquire_data;
            end
        end
        acquire_valid = 1'b0;
        release_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(1'b0, '0, 1'b0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (acquire_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", acquire_ready); end
        n_checks++; if (acquire_tag !== 3'd0) begin n_fail++; $display("FAIL reset_tag: got %0d expected 0", acquire_tag); end
        n_checks++; if (size !== 4'd0) begin n_fail++; $display("FAIL reset_size: got %0d expected 0", size); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < SIZE; i++) begin
            apply(1'b1, 32'h100 + 32'(i), 1'b0, '0);
            n_checks++; if (acquire_tag !== 3'(i)) begin n_fail++; $display("FAIL fill_tag: got %0d expected %0d", acquire_tag, i); end
            tick();
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
        n_checks++; if (size !== 4'd8) begin n_fail++; $display("FAIL fill_size: got %0d expected 8", size); end
        n_checks++; if (acquire_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", acquire_ready); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b expected 0", empty); end
    endtask

    task automatic test_release_from_full();
        test_fill();
        apply(1'b0, '0, 1'b1, 3'd3);
        n_checks++; if (release_data !== 32'h103) begin n_fail++; $display("FAIL rel3_data: got %h expected 00000103", release_data); end
        tick();
        n_checks++; if (size !== 4'd7) begin n_fail++; $display("FAIL rel3_size: got %0d expected 7", size); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rel3_full: got %b expected 0", full); end
        n_checks++; if (acquire_tag !== 3'd3) begin n_fail++; $display("FAIL rel3_tag: got %0d expected 3", acquire_tag); end
    endtask

    task automatic test_release_last();
        do_reset();
        apply(1'b1, 32'h1234, 1'b0, '0);
        tick();
        apply(1'b0, '0, 1'b1, 3'd0);
        n_checks++; if (release_data !== 32'h1234) begin n_fail++; $display("FAIL last_data: got %h expected 00001234", release_data); end
        tick();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL last_empty: got %b expected 1", empty); end
        n_checks++; if (size !== 4'd0) begin n_fail++; $display("FAIL last_size: got %0d expected 0", size); end
        n_checks++; if (acquire_tag !== 3'd0) begin n_fail++; $display("FAIL last_tag: got %0d expected 0", acquire_tag); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        apply(1'b1, 32'h10, 1'b0, '0);
        tick();
        apply(1'b1, 32'h11, 1'b0, '0);
        tick();
        apply(1'b1, 32'hAA, 1'b1, 3'd0);
        n_checks++; if (acquire_tag !== 3'd2) begin n_fail++; $display("FAIL b2b_tag: got %0d expected 2", acquire_tag); end
        tick();
        apply(1'b0, '0, 1'b0, 3'd2);
        n_checks++; if (size !== 4'd2) begin n_fail++; $display("FAIL b2b_size: got %0d expected 2", size); end
        n_checks++; if (acquire_tag !== 3'd0) begin n_fail++; $display("FAIL b2b_next_tag: got %0d expected 0", acquire_tag); end
        n_checks++; if (release_data !== 32'hAA) begin n_fail++; $display("FAIL b2b_data: got %h expected 000000aa", release_data); end
    endtask

    task automatic test_full_acquire_release();
        test_fill();
        apply(1'b1, 32'hDEAD, 1'b1, 3'd5);
        n_checks++; if (acquire_ready !== 1'b0) begin n_fail++; $display("FAIL fullrel_ready: got %b expected 0", acquire_ready); end
        tick();
        n_checks++; if (size !== 4'd7) begin n_fail++; $display("FAIL fullrel_size: got %0d expected 7", size); end
        n_checks++; if (acquire_tag !== 3'd5) begin n_fail++; $display("FAIL fullrel_tag: got %0d expected 5", acquire_tag); end
        apply(1'b1, 32'h55, 1'b0, '0);
        tick();
        apply(1'b0, '0, 1'b0, 3'd5);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL refill_full: got %b expected 1", full); end
        n_checks++; if (release_data !== 32'h55) begin n_fail++; $display("FAIL refill_data: got %h expected 00000055", release_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 32'h200 + 32'(i), 1'b0, '0);
            tick();
        end
        n_checks++; if (size !== 4'd4) begin n_fail++; $display("FAIL mid_pre_size: got %0d expected 4", size); end
        do_reset();
        n_checks++; if (size !== 4'd0) begin n_fail++; $display("FAIL mid_size: got %0d expected 0", size); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b expected 0", full); end
        n_checks++; if (acquire_tag !== 3'd0) begin n_fail++; $display("FAIL mid_tag: got %0d expected 0", acquire_tag); end
    endtask

    task automatic test_random();
        bit               av, rv;
        logic [TAGW-1:0]  rt;
        int               cnt;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            av  = ($urandom_range(0, 3) != 0);
            rv  = 1'b0;
            rt  = TAGW'($urandom_range(0, SIZE - 1));
            cnt = m_count();
            if (cnt > 0 && $urandom_range(0, 1) == 1) begin
                while (!m_valid[rt]) rt = TAGW'($urandom_range(0, SIZE - 1));
                rv = 1'b1;
            end
            apply(av, DATAW'($urandom), rv, rt);
            n_checks++; if (size !== SIZEW'(cnt)) begin n_fail++; $display("FAIL rnd_size cyc %0d: got %0d expected %0d", cyc, size, cnt); end
            n_checks++; if (empty !== (cnt == 0)) begin n_fail++; $display("FAIL rnd_empty cyc %0d: got %b expected %b", cyc, empty, cnt == 0); end
            n_checks++; if (full !== (cnt == SIZE)) begin n_fail++; $display("FAIL rnd_full cyc %0d: got %b expected %b", cyc, full, cnt == SIZE); end
            n_checks++; if (acquire_ready !== (cnt != SIZE)) begin n_fail++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, acquire_ready, cnt != SIZE); end
            if (cnt < SIZE) begin
                n_checks++; if (acquire_tag !== TAGW'(m_free())) begin n_fail++; $display("FAIL rnd_tag cyc %0d: got %0d expected %0d", cyc, acquire_tag, m_free()); end
            end
            if (rv) begin
                n_checks++; if (release_data !== m_data[rt]) begin n_fail++; $display("FAIL rnd_data cyc %0d tag %0d: got %h expected %h", cyc, rt, release_data, m_data[rt]); end
            end
            tick();
        end
    endtask

    initial begin
        reset         = 1'b1;
        acquire_valid = 1'b0;
        acquire_data  = '0;
        release_valid = 1'b0;
        release_tag   = '0;
        @(negedge clk);
        #1;
        test_reset();
        test_fill();
        test_release_from_full();
        test_release_last();
        test_back_to_back();
        test_full_acquire_release();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
